// File: rtl/sdram_init_resp_pkg.sv
// Shared SDRAM command encodings, responder state and error codes.
package sdram_pkg;

   localparam logic [3:0] CMD_NOP = 4'b0111;
   localparam logic [3:0] CMD_PRE = 4'b0010;
   localparam logic [3:0] CMD_AR  = 4'b0001;
   localparam logic [3:0] CMD_MRS = 4'b0000;
   localparam logic [3:0] CMD_ACT = 4'b0011;
   localparam logic [3:0] CMD_RD  = 4'b0101;
   localparam logic [3:0] CMD_WR  = 4'b0100;
   localparam logic [3:0] CMD_BT  = 4'b0110;

   typedef enum logic [2:0] {
      R_PWR   = 3'd0,
      R_TRP   = 3'd1,
      R_TRFC  = 3'd2,
      R_TMRD  = 3'd3,
      R_READY = 3'd4,
      R_ERR   = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      ERR_NONE          = 3'd0,
      ERR_EARLY         = 3'd1,
      ERR_NOT_ALL_BANKS = 3'd2,
      ERR_TIMING        = 3'd3,
      ERR_ORDER         = 3'd4,
      ERR_BAD_MODE      = 3'd5
   } err_t;

   function automatic logic cas_ok(input logic [2:0] cas);
      return (cas == 3'd2) || (cas == 3'd3);
   endfunction

endpackage

// File: rtl/sdram_cmd_decode.sv
// One-hot decode of {cs_n, ras_n, cas_n, we_n}; deselect counts as NOP.
module sdram_cmd_decode
   import sdram_pkg::*;
(
   input  logic [3:0] cmd,
   output logic       is_nop,
   output logic       is_pre,
   output logic       is_ar,
   output logic       is_mrs,
   output logic       is_other
);

   always_comb begin
      is_nop   = cmd[3] | (cmd == CMD_NOP);
      is_pre   = (cmd == CMD_PRE);
      is_ar    = (cmd == CMD_AR);
      is_mrs   = (cmd == CMD_MRS);
      is_other = ~(is_nop | is_pre | is_ar | is_mrs);
   end

endmodule

// File: rtl/sdram_init_resp.sv
// SDRAM power-up init responder/checker. Optional offending-command
// counter output resp_err_cnt when SDRAM_RESP_ERR_CNT_EN is defined.
//
// state   | meaning
// R_PWR   | power-up wait, only NOP/deselect allowed until T_POWER
// R_TRP   | after PRECHARGE-all, waiting tRP then first AUTO REFRESH
// R_TRFC  | after AUTO REFRESH, waiting tRFC then next AR or MRS
// R_TMRD  | after MRS, waiting tMRD before ready
// R_READY | init complete, only MRS re-latch is tracked
// R_ERR   | first error recorded, held until reset
module sdram_init_resp
   import sdram_pkg::*;
#(
   parameter int T_POWER = 20000,
   parameter int T_RP    = 2,
   parameter int T_RFC   = 7,
   parameter int T_MRD   = 2,
   parameter int AR_NUM  = 8
) (
   input  logic        resp_clk,
   input  logic        resp_rst_n,
   input  logic [3:0]  resp_cmd,
   input  logic [1:0]  resp_bank,
   input  logic [12:0] resp_addr,
   output logic        resp_ready,
   output logic [14:0] resp_mode_reg,
   output logic [2:0]  resp_cas_lat,
   output logic [2:0]  resp_burst_len,
   output logic [3:0]  resp_ar_cnt,
   output logic        resp_err,
   output logic [2:0]  resp_err_code
`ifdef SDRAM_RESP_ERR_CNT_EN
   ,
   output logic [7:0]  resp_err_cnt
`endif
);

   // Counter value c means c+1 cycles have elapsed since the last reload.
   localparam logic [14:0] PWR_LIM = 15'(T_POWER - 1);
   localparam logic [14:0] RP_LIM  = 15'(T_RP - 1);
   localparam logic [14:0] RFC_LIM = 15'(T_RFC - 1);
   localparam logic [14:0] MRD_LIM = 15'(T_MRD - 1);
   localparam logic [3:0]  AR_LIM  = 4'(AR_NUM);

   logic        is_nop, is_pre, is_ar, is_mrs, is_other;
   state_t      state;
   err_t        code, err_code;
   logic [14:0] cnt;
   logic [14:0] new_mode;
   logic        accept, latch, offend;

   sdram_cmd_decode u_dec (
      .cmd      (resp_cmd),
      .is_nop   (is_nop),
      .is_pre   (is_pre),
      .is_ar    (is_ar),
      .is_mrs   (is_mrs),
      .is_other (is_other)
   );

   assign new_mode       = {resp_bank, resp_addr};
   assign resp_cas_lat   = resp_mode_reg[6:4];
   assign resp_burst_len = resp_mode_reg[2:0];
   assign resp_err_code  = err_code;

   // Branch order encodes "lowest code wins" when several checks fail.
   always_comb begin
      code   = ERR_NONE;
      accept = 1'b0;
      latch  = 1'b0;
      offend = 1'b0;
      case (state)
         R_PWR: if (!is_nop) begin
            if (cnt < PWR_LIM)                code = ERR_EARLY;
            else if (is_pre && resp_addr[10]) accept = 1'b1;
            else if (is_pre)                  code = ERR_NOT_ALL_BANKS;
            else if (is_ar || is_mrs || is_other) code = ERR_ORDER;
         end
         R_TRP: if (!is_nop) begin
            if (cnt < RP_LIM) code = ERR_TIMING;
            else if (is_ar)   accept = 1'b1;
            else              code = ERR_ORDER;
         end
         R_TRFC: if (!is_nop) begin
            if (cnt < RFC_LIM)                      code = ERR_TIMING;
            else if (is_ar && resp_ar_cnt < AR_LIM) accept = 1'b1;
            else if (is_mrs && resp_ar_cnt == AR_LIM) begin
               latch = 1'b1;
               if (!cas_ok(new_mode[6:4])) code = ERR_BAD_MODE;
            end
            else code = ERR_ORDER;
         end
         R_TMRD: if (!is_nop && cnt < MRD_LIM) code = ERR_TIMING;
         R_READY: if (is_mrs) begin
            latch = 1'b1;
            if (!cas_ok(new_mode[6:4])) code = ERR_BAD_MODE;
         end
`ifdef SDRAM_RESP_ERR_CNT_EN
         R_ERR: offend = !is_nop;
`endif
         default: ;
      endcase
      if (code != ERR_NONE) offend = 1'b1;
   end

   always_ff @(posedge resp_clk or negedge resp_rst_n) begin
      if (!resp_rst_n) begin
         state         <= R_PWR;
         cnt           <= '0;
         resp_ready    <= 1'b0;
         resp_mode_reg <= '0;
         resp_ar_cnt   <= '0;
         resp_err      <= 1'b0;
         err_code      <= ERR_NONE;
`ifdef SDRAM_RESP_ERR_CNT_EN
         resp_err_cnt  <= '0;
`endif
      end else begin
         if (cnt != '1) cnt <= cnt + 15'd1;
         if (latch) resp_mode_reg <= new_mode;
`ifdef SDRAM_RESP_ERR_CNT_EN
         if (offend && resp_err_cnt != 8'hFF) resp_err_cnt <= resp_err_cnt + 8'd1;
`endif
         if (code != ERR_NONE) begin
            state      <= R_ERR;
            resp_err   <= 1'b1;
            resp_ready <= 1'b0;
            err_code   <= code;
         end else begin
            case (state)
               R_PWR: if (accept) begin
                  state <= R_TRP;
                  cnt   <= '0;
               end
               R_TRP, R_TRFC: if (accept) begin
                  state <= R_TRFC;
                  cnt   <= '0;
                  if (resp_ar_cnt != 4'hF) resp_ar_cnt <= resp_ar_cnt + 4'd1;
               end else if (latch) begin
                  state <= R_TMRD;
                  cnt   <= '0;
               end
               R_TMRD: if (cnt >= MRD_LIM) begin
                  state      <= R_READY;
                  resp_ready <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   logic unused_offend;
   assign unused_offend = offend;

endmodule
